// File: rtl/dtc_event_sync.sv
// Fans a front-end trigger out to the DTC channels and merges their per-channel
// event-stored flags into one event-complete flag, with timeout and abort.
module dtc_event_sync #(
  parameter int NCH     = 20,
  parameter int TIMEOUT = 40000
) (
  input  logic             dcsclk,
  input  logic             reset_n,
  input  logic             FeeTrig,
  input  logic             rdocmd,
  input  logic             abortcmd,
  input  logic [NCH-1:0]   dtc_mask,
  input  logic [NCH-1:0]   DtcRamFlag_i,
  input  logic             DtcRamReadConfirm,
  output logic [NCH-1:0]   FeeTrig_o,
  output logic [NCH-1:0]   rdocmd_o,
  output logic [NCH-1:0]   abortcmd_o,
  output logic [NCH-1:0]   DTCEventRdy,
  output logic             DtcRamFlag,
  output logic             busy,
  output logic             timeout_flag,
  output logic [NCH-1:0]   missing,
  output logic [15:0]      evt_cnt,
  output logic [15:0]      tmo_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, ABORT, READY} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]     rst_sync;
  logic           rst_int_n;
  state_t         state, state_n;
  logic [NCH-1:0] mask_l, mask_n;
  logic [15:0]    wait_cnt, wait_cnt_n;
  logic [NCH-1:0] trig_n, abort_n, missing_n;
  logic           tmo_n, evt_inc, tmo_inc;
  logic           complete;

  // Assertion is immediate; release reaches the datapath two edges later.
  always_ff @(posedge dcsclk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];
  assign complete  = &(DtcRamFlag_i | mask_l);

  always_comb begin
    state_n    = state;
    mask_n     = mask_l;
    wait_cnt_n = wait_cnt;
    trig_n     = '0;
    abort_n    = '0;
    missing_n  = missing;
    tmo_n      = 1'b0;
    evt_inc    = 1'b0;
    tmo_inc    = 1'b0;
    if (abortcmd && state != IDLE) begin
      abort_n   = ~mask_l;
      missing_n = '0;
      state_n   = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (abortcmd) begin
            abort_n = ~dtc_mask;
          end else if (FeeTrig && !(&dtc_mask)) begin
            trig_n     = ~dtc_mask;
            mask_n     = dtc_mask;
            wait_cnt_n = '0;
            state_n    = WAIT;
          end
        end
        WAIT: begin
          wait_cnt_n = wait_cnt + 16'd1;
          if (complete)                  state_n = READY;
          else if (wait_cnt == CNT_LAST) state_n = ABORT;
        end
        ABORT: begin
          missing_n = ~DtcRamFlag_i & ~mask_l;
          abort_n   = ~DtcRamFlag_i & ~mask_l;
          tmo_n     = 1'b1;
          tmo_inc   = 1'b1;
          state_n   = READY;
        end
        READY: begin
          if (DtcRamReadConfirm) begin
            evt_inc   = 1'b1;
            missing_n = '0;
            state_n   = IDLE;
          end
        end
      endcase
    end
  end

  // Every output is a flop; flags/ready are derived from the state being entered.
  always_ff @(posedge dcsclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= IDLE;
      mask_l       <= '0;
      wait_cnt     <= '0;
      FeeTrig_o    <= '0;
      rdocmd_o     <= '0;
      abortcmd_o   <= '0;
      DTCEventRdy  <= '0;
      DtcRamFlag   <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      missing      <= '0;
      evt_cnt      <= '0;
      tmo_cnt      <= '0;
    end else begin
      state        <= state_n;
      mask_l       <= mask_n;
      wait_cnt     <= wait_cnt_n;
      FeeTrig_o    <= trig_n;
      rdocmd_o     <= rdocmd ? ~dtc_mask : '0;
      abortcmd_o   <= abort_n;
      DTCEventRdy  <= (state_n == IDLE) ? '0 : (DtcRamFlag_i | mask_n);
      DtcRamFlag   <= (state_n == READY);
      busy         <= (state_n != IDLE);
      timeout_flag <= tmo_n;
      missing      <= missing_n;
      if (evt_inc) evt_cnt <= evt_cnt + 16'd1;
      if (tmo_inc) tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dtc_event_sync.sv
// Bench for dtc_event_sync: two instances (short and longer timeout) share stimulus
// and are compared every cycle against an event-level reference model.
module tb_dtc_event_sync;

  localparam int NCH   = 20;
  localparam int TMO_A = 8;
  localparam int TMO_B = 16;
  localparam logic [NCH-1:0] ONES = '1;
  localparam logic [NCH-1:0] ONE  = 1;
  localparam int P_IDLE = 0, P_WAIT = 1, P_TMO = 2, P_READY = 3;

  logic dcsclk = 1'b0;
  always #5 dcsclk = ~dcsclk;

  logic           reset_n, FeeTrig, rdocmd, abortcmd, DtcRamReadConfirm;
  logic [NCH-1:0] dtc_mask, DtcRamFlag_i;

  logic [NCH-1:0] feetrig_o [2];
  logic [NCH-1:0] rdocmd_o  [2];
  logic [NCH-1:0] abort_o   [2];
  logic [NCH-1:0] rdy_o     [2];
  logic [NCH-1:0] missing_o [2];
  logic           flag_o    [2];
  logic           busy_o    [2];
  logic           tflag_o   [2];
  logic [15:0]    evt_o     [2];
  logic [15:0]    tcnt_o    [2];

  dtc_event_sync #(.NCH(NCH), .TIMEOUT(TMO_A)) dut_a (
    .dcsclk(dcsclk), .reset_n(reset_n), .FeeTrig(FeeTrig), .rdocmd(rdocmd),
    .abortcmd(abortcmd), .dtc_mask(dtc_mask), .DtcRamFlag_i(DtcRamFlag_i),
    .DtcRamReadConfirm(DtcRamReadConfirm), .FeeTrig_o(feetrig_o[0]),
    .rdocmd_o(rdocmd_o[0]), .abortcmd_o(abort_o[0]), .DTCEventRdy(rdy_o[0]),
    .DtcRamFlag(flag_o[0]), .busy(busy_o[0]), .timeout_flag(tflag_o[0]),
    .missing(missing_o[0]), .evt_cnt(evt_o[0]), .tmo_cnt(tcnt_o[0])
  );

  dtc_event_sync #(.NCH(NCH), .TIMEOUT(TMO_B)) dut_b (
    .dcsclk(dcsclk), .reset_n(reset_n), .FeeTrig(FeeTrig), .rdocmd(rdocmd),
    .abortcmd(abortcmd), .dtc_mask(dtc_mask), .DtcRamFlag_i(DtcRamFlag_i),
    .DtcRamReadConfirm(DtcRamReadConfirm), .FeeTrig_o(feetrig_o[1]),
    .rdocmd_o(rdocmd_o[1]), .abortcmd_o(abort_o[1]), .DTCEventRdy(rdy_o[1]),
    .DtcRamFlag(flag_o[1]), .busy(busy_o[1]), .timeout_flag(tflag_o[1]),
    .missing(missing_o[1]), .evt_cnt(evt_o[1]), .tmo_cnt(tcnt_o[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: event phase, trigger cycle and expected outputs per instance.
  int             cyc_n;
  int             sync_cnt;
  int             ph     [2];
  int             start  [2];
  logic [NCH-1:0] m_mask [2];
  logic [NCH-1:0] e_trig [2], e_rdo [2], e_abo [2], e_rdy [2], e_miss [2];
  logic           e_flag [2], e_busy [2], e_tmo [2];
  logic [15:0]    e_evt  [2], e_tcnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tmo_of(input int k);
    return (k == 0) ? TMO_A : TMO_B;
  endfunction

  task automatic model_clear();
    sync_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_IDLE; start[k] = 0; m_mask[k] = '0;
      e_trig[k] = '0; e_rdo[k] = '0; e_abo[k] = '0; e_rdy[k] = '0; e_miss[k] = '0;
      e_flag[k] = 1'b0; e_busy[k] = 1'b0; e_tmo[k] = 1'b0;
      e_evt[k] = '0; e_tcnt[k] = '0;
    end
  endtask

  task automatic model_step();
    logic all_in;
    cyc_n++;
    if (!reset_n) begin
      model_clear();
      return;
    end
    if (sync_cnt < 2) begin
      sync_cnt++;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      all_in   = ((DtcRamFlag_i | m_mask[k]) == ONES);
      e_trig[k] = '0;
      e_abo[k]  = '0;
      e_tmo[k]  = 1'b0;
      e_rdo[k]  = rdocmd ? ~dtc_mask : '0;
      if (abortcmd) begin
        if (ph[k] == P_IDLE) e_abo[k] = ~dtc_mask;
        else begin
          e_abo[k] = ~m_mask[k]; ph[k] = P_IDLE; e_miss[k] = '0;
        end
      end else begin
        case (ph[k])
          P_IDLE:
            if (FeeTrig && dtc_mask != ONES) begin
              e_trig[k] = ~dtc_mask; m_mask[k] = dtc_mask;
              start[k] = cyc_n; ph[k] = P_WAIT;
            end
          P_WAIT:
            if (all_in) ph[k] = P_READY;
            else if (cyc_n - start[k] == tmo_of(k)) ph[k] = P_TMO;
          P_TMO: begin
            e_miss[k] = ~DtcRamFlag_i & ~m_mask[k];
            e_abo[k]  = e_miss[k];
            e_tmo[k]  = 1'b1;
            e_tcnt[k] = e_tcnt[k] + 16'd1;
            ph[k]     = P_READY;
          end
          default:
            if (DtcRamReadConfirm) begin
              ph[k] = P_IDLE; e_evt[k] = e_evt[k] + 16'd1; e_miss[k] = '0;
            end
        endcase
      end
      e_rdy[k]  = (ph[k] != P_IDLE) ? (DtcRamFlag_i | m_mask[k]) : '0;
      e_flag[k] = (ph[k] == P_READY);
      e_busy[k] = (ph[k] != P_IDLE);
    end
  endtask

  task automatic compare_all(input int k);
    string p;
    p = (k == 0) ? "a." : "b.";
    check({p, "FeeTrig_o"},    feetrig_o[k], e_trig[k]);
    check({p, "rdocmd_o"},     rdocmd_o[k],  e_rdo[k]);
    check({p, "abortcmd_o"},   abort_o[k],   e_abo[k]);
    check({p, "DTCEventRdy"},  rdy_o[k],     e_rdy[k]);
    check({p, "DtcRamFlag"},   flag_o[k],    e_flag[k]);
    check({p, "busy"},         busy_o[k],    e_busy[k]);
    check({p, "timeout_flag"}, tflag_o[k],   e_tmo[k]);
    check({p, "missing"},      missing_o[k], e_miss[k]);
    check({p, "evt_cnt"},      evt_o[k],     e_evt[k]);
    check({p, "tmo_cnt"},      tcnt_o[k],    e_tcnt[k]);
  endtask

  task automatic tick();
    @(posedge dcsclk);
    model_step();
    #1;
    compare_all(0);
    compare_all(1);
  endtask

  task automatic quiet();
    FeeTrig = 1'b0; rdocmd = 1'b0; abortcmd = 1'b0; DtcRamReadConfirm = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    dtc_mask = '0; DtcRamFlag_i = '0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic trigger(input logic [NCH-1:0] m);
    dtc_mask = m; FeeTrig = 1'b1;
    tick();
    FeeTrig = 1'b0;
  endtask

  initial begin
    cyc_n = 0;
    model_clear();
    quiet();
    dtc_mask = '0; DtcRamFlag_i = '0;
    reset_n = 1'b1;
    #2;
    do_reset();
    check("rst.busy", busy_o[0], 1'b0);
    check("rst.evt_cnt", evt_o[1], 16'h0000);

    // Normal event with two masked channels, flags arrive late.
    trigger(20'h00003);
    check("r041.trig", feetrig_o[1], 20'hFFFFC);
    check("r041.busy", busy_o[1], 1'b1);
    tick();
    check("r041.trig_off", feetrig_o[1], '0);
    repeat (8) tick();
    DtcRamFlag_i = 20'hFFFFC;
    tick();
    check("r041.flag", flag_o[1], 1'b1);
    DtcRamReadConfirm = 1'b1;
    tick();
    DtcRamReadConfirm = 1'b0;
    check("r041.evt_cnt", evt_o[1], 16'd1);
    check("r041.busy_off", busy_o[1], 1'b0);

    // Timeout with four channels missing.
    do_reset();
    DtcRamFlag_i = 20'hFFFF0;
    trigger('0);
    repeat (8) tick();
    check("r042.no_early_tmo", tflag_o[0], 1'b0);
    tick();
    check("r042.missing", missing_o[0], 20'h0000F);
    check("r042.abortcmd", abort_o[0], 20'h0000F);
    check("r042.tflag", tflag_o[0], 1'b1);
    check("r042.tmo_cnt", tcnt_o[0], 16'd1);
    check("r042.flag", flag_o[0], 1'b1);
    tick();
    check("r042.abort_off", abort_o[0], '0);
    check("r042.tflag_off", tflag_o[0], 1'b0);
    DtcRamReadConfirm = 1'b1;
    tick();
    DtcRamReadConfirm = 1'b0;
    check("r042.missing_clr", missing_o[0], '0);
    check("r036.b_ignores_confirm", busy_o[1], 1'b1);
    repeat (10) tick();
    DtcRamReadConfirm = 1'b1;
    tick();
    DtcRamReadConfirm = 1'b0;

    // Last flag lands on the final WAIT cycle: completion beats timeout.
    do_reset();
    DtcRamFlag_i = 20'hFFFFE;
    trigger('0);
    repeat (7) tick();
    DtcRamFlag_i = ONES;
    tick();
    check("r043.flag", flag_o[0], 1'b1);
    check("r043.tflag", tflag_o[0], 1'b0);
    tick();
    check("r043.tmo_cnt", tcnt_o[0], 16'd0);
    check("r043.abort", abort_o[0], '0);
    DtcRamReadConfirm = 1'b1;
    tick();
    DtcRamReadConfirm = 1'b0;

    // All-masked trigger, retrigger in WAIT, mask change in WAIT.
    do_reset();
    trigger(ONES);
    check("r044.allmask_trig", feetrig_o[0], '0);
    check("r044.allmask_busy", busy_o[0], 1'b0);
    trigger(20'h000FF);
    check("r044.trig", feetrig_o[0], 20'hFFF00);
    trigger('0);
    check("r044.retrig_ignored", feetrig_o[0], '0);
    tick();
    check("r044.rdy_latched", rdy_o[0], 20'h000FF);
    abortcmd = 1'b1;
    tick();
    abortcmd = 1'b0;
    check("r044.abort_mask_l", abort_o[0], 20'hFFF00);
    check("r044.abort_idle", busy_o[0], 1'b0);

    // Abort beats confirm in READY; then async reset in WAIT.
    do_reset();
    DtcRamFlag_i = 20'hFFFFC;
    trigger(20'h00003);
    tick();
    dtc_mask = '0;
    abortcmd = 1'b1; DtcRamReadConfirm = 1'b1;
    tick();
    quiet();
    check("r045.abortcmd", abort_o[0], 20'hFFFFC);
    check("r045.evt_cnt", evt_o[0], 16'd0);
    check("r045.flag", flag_o[0], 1'b0);
    DtcRamFlag_i = '0;
    trigger('0);
    tick();
    reset_n = 1'b0;
    #1;
    model_clear();
    compare_all(0);
    compare_all(1);
    check("r040.no_abortcmd", abort_o[0], '0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Event counter wrap.
    force dut_a.evt_cnt = 16'hFFFF;
    force dut_b.evt_cnt = 16'hFFFF;
    e_evt[0] = 16'hFFFF;
    e_evt[1] = 16'hFFFF;
    tick();
    release dut_a.evt_cnt;
    release dut_b.evt_cnt;
    tick();
    DtcRamFlag_i = ONES;
    trigger('0);
    tick();
    DtcRamReadConfirm = 1'b1;
    tick();
    DtcRamReadConfirm = 1'b0;
    check("r046.wrap", evt_o[0], 16'h0000);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      FeeTrig           = ($urandom_range(0, 5) == 0);
      abortcmd          = ($urandom_range(0, 39) == 0);
      DtcRamReadConfirm = ($urandom_range(0, 2) == 0);
      rdocmd            = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0:       dtc_mask = '0;
          1:       dtc_mask = ONES;
          default: dtc_mask = NCH'($urandom) & NCH'($urandom);
        endcase
      end
      case ($urandom_range(0, 15))
        0:       DtcRamFlag_i = '0;
        1:       DtcRamFlag_i = ONES;
        2, 3, 4, 5, 6, 7, 8, 9:
                 DtcRamFlag_i = DtcRamFlag_i | (ONE << $urandom_range(0, NCH - 1));
        default: DtcRamFlag_i = DtcRamFlag_i;
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
